// File: rtl/ex_alu_pkg.sv
// Shared ALU control codes and FSM state encoding for the EX-stage execution unit.
// The MUL state exists only when EX_ALU_MUL_EN is defined.
package ex_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1
`ifdef EX_ALU_MUL_EN
    ,
    StMul  = 2'd2
`endif
  } alu_state_e;

endpackage

// File: rtl/ex_alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle for XLEN cycles.
// Only instantiated by ex_alu_exec when EX_ALU_MUL_EN is defined.
module ex_alu_mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = CntW'(XLEN);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  // The final step is in flight: expose its sum so the caller can register it this edge.
  assign done_o    = (cnt_q == CntW'(1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_alu_exec.sv
// EX-stage execution unit: single-cycle AND/OR/ADD/SUB into a valid/ready output register.
// Define EX_ALU_MUL_EN to add the iterative multiplier (code 1000); otherwise 1000 is illegal.
module ex_alu_exec
  import ex_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            accept;
  logic            is_mul;
  logic            mul_start;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
`ifdef EX_ALU_MUL_EN
      ALU_MUL: alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef EX_ALU_MUL_EN
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign is_mul = (alu_ctrl == ALU_MUL);

  ex_alu_mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (mul_start),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  assign in_ready  = !reset && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    mul_start = 1'b0;
    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
`ifdef EX_ALU_MUL_EN
            state_d   = StMul;
`endif
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = StHold;
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef EX_ALU_MUL_EN
      StMul: begin
        if (mul_done) begin
          result_d  = mul_product;
          zero_d    = (mul_product == '0);
          illegal_d = 1'b0;
          state_d   = StHold;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_exec.sv
// Scoreboard bench for ex_alu_exec: expectations queued on input transfer, checked on output transfer.
module tb_ex_alu_exec;
  import ex_alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_alu_exec #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    exp_t e;
    e.ill = 1'b0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
`ifdef EX_ALU_MUL_EN
      4'b1000: e.res = a * b;
`endif
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic ordy);
    in_valid  = v;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
  endtask

  // Sample both handshakes mid-low-phase, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    if (in_valid && in_ready) sb_q.push_back(model(alu_ctrl, op_a, op_b));
    if (out_valid && out_ready) begin
      check_eq("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("sb_result", 64'(result), 64'(e.res));
        check_eq("sb_zero", 64'(zero), 64'(e.zero));
        check_eq("sb_illegal", 64'(illegal), 64'(e.ill));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_zero", 64'(zero), 64'd0);
    check_eq("rst_illegal", 64'(illegal), 64'd0);
    sb_q.delete();
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

`ifdef EX_ALU_MUL_EN
  task automatic mul_run(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int n  = 0;
    int hi = 0;
    drive(1'b1, ALU_MUL, a, b, 1'b1);
    tick();
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    while (!out_valid && n < 100) begin
      n++;
      if (in_ready) hi++;
      tick();
    end
    check_eq("mul_latency", 64'(n), 64'd32);
    check_eq("mul_in_ready_low", 64'(hi), 64'd0);
    tick();
  endtask
`endif

  initial begin
    int n;
    reset = 1'b1;
    drive(1'b0, 4'b0000, '0, '0, 1'b0);
    @(negedge clk);
    do_reset();

    // 1: wrap-around ADD
    drive(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    tick();
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_zero", 64'(zero), 64'd1);
    drive(1'b0, ALU_ADD, '0, '0, 1'b1);
    tick();

    // 2: SUB stalled by downstream, AND queued behind it
    drive(1'b1, ALU_SUB, 32'd5, 32'd7, 1'b0);
    tick();
    drive(1'b1, ALU_AND, 32'hF0F0, 32'hFF00, 1'b0);
    repeat (3) begin
      #1;
      check_eq("t2_in_ready", 64'(in_ready), 64'd0);
      check_eq("t2_hold", 64'(result), 64'hFFFF_FFFE);
      check_eq("t2_valid", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("t2_accept", 64'(in_ready), 64'd1);
    tick();
    check_eq("t2_and", 64'(result), 64'hF000);
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    tick();
    check_eq("t2_drain", 64'(out_valid), 64'd0);

    // 3: back-to-back with no bubble
    drive(1'b1, ALU_AND, 32'hF0F0, 32'hFF00, 1'b1);
    tick();
    check_eq("t3_and", 64'(result), 64'hF000);
    drive(1'b1, ALU_OR, 32'h0F, 32'hF0, 1'b1);
    #1;
    check_eq("t3_in_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("t3_or", 64'(result), 64'hFF);
    check_eq("t3_valid", 64'(out_valid), 64'd1);
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    tick();

    // 4: unsupported codes
    drive(1'b1, 4'b0101, 32'h1234, 32'h5678, 1'b1);
    tick();
    check_eq("t4_illegal", 64'(illegal), 64'd1);
`ifndef EX_ALU_MUL_EN
    drive(1'b1, 4'b1000, 32'd3, 32'd4, 1'b1);
    tick();
    check_eq("t4_mul_illegal", 64'(illegal), 64'd1);
`endif
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    tick();

`ifdef EX_ALU_MUL_EN
    // 5: multiplier
    mul_run(32'd12345, 32'd678);
    mul_run(32'h10000, 32'h10000);
`endif

    // 6: reset in HOLD, then a normal ADD
    drive(1'b1, ALU_ADD, 32'd2, 32'd3, 1'b0);
    tick();
    do_reset();
    drive(1'b1, ALU_ADD, 32'd10, 32'd20, 1'b1);
    tick();
    check_eq("t6_add", 64'(result), 64'd30);
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    tick();
`ifdef EX_ALU_MUL_EN
    drive(1'b1, ALU_MUL, 32'd7, 32'd9, 1'b1);
    tick();
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    repeat (5) tick();
    do_reset();
    n = 0;
    repeat (40) begin
      if (out_valid) n++;
      tick();
    end
    check_eq("t6_mul_abort", 64'(n), 64'd0);
`endif

    // Mixed random traffic with random back-pressure
    for (int i = 0; i < 60; i++) begin
      logic [3:0] codes [6];
      codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, 4'b0101, 4'b1000};
      drive(1'($urandom_range(0, 1)), codes[$urandom_range(0, 5)], $urandom, $urandom,
            1'($urandom_range(0, 3) != 0));
      tick();
    end
    drive(1'b0, ALU_AND, '0, '0, 1'b1);
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      n++;
      tick();
    end
    check_eq("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
